// File: rtl/c7bicu_fetch_bridge.sv
// Instruction-side fetch bridge: serves IFU fetches from a one-line (8-byte) buffer,
// or reads the line over the BIU on a miss. At most one request is in flight.
module c7bicu_fetch_bridge #(
  parameter int LBUF_EN = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ifu_icu_req_ic1,
  input  logic [31:0]      ifu_icu_addr_ic1,
  output logic             icu_ifu_ack_ic1,
  output logic             icu_ifu_data_valid_ic2,
  output logic [63:0]      icu_ifu_data_ic2,
  input  logic             csr_icu_inv,
  output logic             icu_biu_req,
  output logic [31:0]      icu_biu_addr,
  input  logic             biu_icu_gnt,
  input  logic             biu_icu_rvalid,
  input  logic [63:0]      biu_icu_rdata,
  output logic [CNT_W-1:0] icu_hit_cnt,
  output logic [CNT_W-1:0] icu_miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_BREQ,
    S_BWAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [28:0]      tag_q, tag_d;
  logic [28:0]      buf_tag_q, buf_tag_d;
  logic             buf_valid_q, buf_valid_d;
  logic [63:0]      buf_data_q, buf_data_d;
  logic [63:0]      data_q, data_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             lookup_hit;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^ifu_icu_addr_ic1[2:0];

  always_comb begin
    lookup_hit = (LBUF_EN != 0) && buf_valid_q && !csr_icu_inv &&
                 (buf_tag_q == ifu_icu_addr_ic1[31:3]);

    state_d                = state_q;
    tag_d                  = tag_q;
    buf_tag_d              = buf_tag_q;
    buf_valid_d            = buf_valid_q;
    buf_data_d             = buf_data_q;
    data_d                 = data_q;
    hit_cnt_d              = hit_cnt_q;
    miss_cnt_d             = miss_cnt_q;
    icu_ifu_ack_ic1        = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_biu_req            = 1'b0;

    case (state_q)
      S_IDLE: begin
        icu_ifu_ack_ic1 = ifu_icu_req_ic1;
        if (ifu_icu_req_ic1) begin
          tag_d = ifu_icu_addr_ic1[31:3];
          if (lookup_hit) begin
            data_d  = buf_data_q;
            state_d = S_HIT;
          end else begin
            state_d = S_BREQ;
          end
        end
      end
      S_HIT: begin
        icu_ifu_data_valid_ic2 = 1'b1;
        hit_cnt_d              = hit_cnt_q + CNT_W'(1);
        state_d                = S_IDLE;
      end
      S_BREQ: begin
        icu_biu_req = 1'b1;
        if (biu_icu_gnt) begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = S_BWAIT;
        end
      end
      S_BWAIT: begin
        if (biu_icu_rvalid) begin
          data_d      = biu_icu_rdata;
          buf_data_d  = biu_icu_rdata;
          buf_tag_d   = tag_q;
          buf_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        icu_ifu_data_valid_ic2 = 1'b1;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Invalidate wins over a same-cycle fill: data still returns, line stays invalid.
    if (csr_icu_inv) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      data_q      <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      data_q      <= data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign icu_ifu_data_ic2 = data_q;
  assign icu_biu_addr     = {tag_q, 3'b000};
  assign icu_hit_cnt      = hit_cnt_q;
  assign icu_miss_cnt     = miss_cnt_q;

  // Read data is only legal while a BIU read is outstanding.
  rvalid_only_in_bwait: assert property (@(posedge clk) disable iff (!resetn)
    biu_icu_rvalid |-> (state_q == S_BWAIT));

endmodule

// File: tb/tb_c7bicu_fetch_bridge.sv
// Bench for c7bicu_fetch_bridge: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_c7bicu_fetch_bridge;

  localparam int LBUF = 1;
  localparam int CW   = 32;

  logic          clk;
  logic          resetn;
  logic          req;
  logic [31:0]   addr;
  logic          ack;
  logic          valid;
  logic [63:0]   data;
  logic          inv;
  logic          biu_req;
  logic [31:0]   biu_addr;
  logic          gnt;
  logic          rvalid;
  logic [63:0]   rdata;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  c7bicu_fetch_bridge #(.LBUF_EN(LBUF), .CNT_W(CW)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .icu_ifu_ack_ic1        (ack),
    .icu_ifu_data_valid_ic2 (valid),
    .icu_ifu_data_ic2       (data),
    .csr_icu_inv            (inv),
    .icu_biu_req            (biu_req),
    .icu_biu_addr           (biu_addr),
    .biu_icu_gnt            (gnt),
    .biu_icu_rvalid         (rvalid),
    .biu_icu_rdata          (rdata),
    .icu_hit_cnt            (hit_cnt),
    .icu_miss_cnt           (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding fetch; a hit answers next cycle, a miss waits for gnt then data.
  logic        m_busy, m_vnow, m_vhit, m_wgnt, m_wdat, m_bv;
  logic [28:0] m_tag, m_btag;
  logic [63:0] m_data, m_bdata;
  logic [CW-1:0] m_hits, m_miss;
  logic        ack_e, wg, wd;

  always @(negedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_vnow = 0; m_vhit = 0; m_wgnt = 0; m_wdat = 0; m_bv = 0;
      m_tag = '0; m_btag = '0; m_data = '0; m_bdata = '0; m_hits = '0; m_miss = '0;
      chk("rst_ack", ack, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_biu_req", biu_req, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);
    end else begin
      ack_e = req && !m_busy;
      chk("ack", ack, ack_e);
      chk("valid", valid, m_vnow);
      chk("data", data, m_data);
      chk("biu_req", biu_req, m_wgnt);
      if (m_wgnt) chk("biu_addr", biu_addr, {m_tag, 3'b000});
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_miss);

      wg = m_wgnt;
      wd = m_wdat;
      if (m_vnow) begin
        m_busy = 0;
        m_vnow = 0;
        if (m_vhit) m_hits = m_hits + 1;
      end
      if (ack_e) begin
        m_busy = 1;
        if (LBUF != 0 && m_bv && m_btag == addr[31:3] && !inv) begin
          m_vnow = 1; m_vhit = 1; m_data = m_bdata;
        end else begin
          m_wgnt = 1; m_vhit = 0; m_tag = addr[31:3];
        end
      end
      if (wg && gnt) begin
        m_wgnt = 0; m_wdat = 1; m_miss = m_miss + 1;
      end
      if (wd && rvalid) begin
        m_wdat = 0; m_vnow = 1; m_data = rdata;
        m_bv = 1; m_btag = m_tag; m_bdata = rdata;
      end
      if (inv) m_bv = 0;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Miss with gnt gd cycles after ack, rvalid rd cycles after gnt.
  task automatic miss(input logic [31:0] a, input logic [31:0] ea, input int gd, input int rd,
                      input logic [63:0] d, input logic inv_ack, input logic inv_rv,
                      input logic hold);
    req = 1; addr = a; inv = inv_ack;
    cyc;
    inv = 0;
    if (!hold) req = 0;
    chk("miss_breq", biu_req, 1);
    chk("miss_baddr", biu_addr, ea);
    repeat (gd - 1) cyc;
    chk("miss_breq_held", biu_req, 1);
    chk("miss_ack_low", ack, 0);
    gnt = 1;
    cyc;
    gnt = 0; req = 0;
    repeat (rd - 1) cyc;
    rvalid = 1; rdata = d; inv = inv_rv;
    cyc;
    rvalid = 0; inv = 0;
    chk("miss_valid", valid, 1);
    chk("miss_data", data, d);
    cyc;
  endtask

  task automatic hit(input logic [31:0] a, input logic [63:0] d);
    req = 1; addr = a;
    cyc;
    req = 0;
    chk("hit_valid", valid, 1);
    chk("hit_data", data, d);
    chk("hit_no_breq", biu_req, 0);
    cyc;
  endtask

  initial begin
    resetn = 0; req = 0; addr = '0; inv = 0; gnt = 0; rvalid = 0; rdata = '0;
    repeat (3) cyc;
    resetn = 1;
    cyc;

    // Cold miss, then hit on the same line
    miss(32'h1c00_0004, 32'h1c00_0000, 2, 2, 64'h0000_0013_0280_0400, 0, 0, 0);
    chk("t1_miss_cnt", miss_cnt, 1);
    hit(32'h1c00_0000, 64'h0000_0013_0280_0400);
    chk("t2_hit_cnt", hit_cnt, 1);

    // Sequential miss with req held: one miss then back-to-back hits
    req = 1; addr = 32'h1c00_0008;
    cyc;
    chk("t3_baddr", biu_addr, 32'h1c00_0008);
    gnt = 1;
    cyc;
    gnt = 0; rvalid = 1; rdata = 64'h1111_2222_3333_4444;
    cyc;
    rvalid = 0;
    repeat (6) cyc;
    req = 0;
    repeat (2) cyc;
    chk("t3_hit_cnt", hit_cnt, 4);
    chk("t3_miss_cnt", miss_cnt, 2);

    // Invalidate pulse forces a miss
    inv = 1;
    cyc;
    inv = 0;
    miss(32'h1c00_0008, 32'h1c00_0008, 1, 1, 64'h5555_6666_7777_8888, 0, 0, 0);
    chk("t4a_miss_cnt", miss_cnt, 3);

    // Invalidate with rvalid: data returned, line left invalid
    miss(32'h1c00_0010, 32'h1c00_0010, 1, 3, 64'hdead_beef_0bad_f00d, 0, 1, 0);
    miss(32'h1c00_0014, 32'h1c00_0010, 1, 1, 64'h0123_4567_89ab_cdef, 0, 0, 0);
    chk("t4b_miss_cnt", miss_cnt, 5);

    // Invalidate coincident with ack on a valid line
    miss(32'h1c00_0010, 32'h1c00_0010, 1, 1, 64'hfeed_face_cafe_babe, 1, 0, 0);
    chk("t4c_miss_cnt", miss_cnt, 6);
    chk("t4c_hit_cnt", hit_cnt, 4);

    // Back-pressure: gnt withheld 10 cycles with req held
    miss(32'h1c00_0020, 32'h1c00_0020, 11, 2, 64'haaaa_bbbb_cccc_dddd, 0, 0, 1);
    chk("t5_miss_cnt", miss_cnt, 7);

    // Reset in BWAIT
    req = 1; addr = 32'h1c00_0018;
    cyc;
    req = 0; gnt = 1;
    cyc;
    gnt = 0;
    cyc;
    chk("t6_pre_miss_cnt", miss_cnt, 8);
    resetn = 0;
    #1;
    chk("t6_biu_req", biu_req, 0);
    chk("t6_valid", valid, 0);
    chk("t6_miss_cnt", miss_cnt, 0);
    chk("t6_hit_cnt", hit_cnt, 0);
    repeat (2) cyc;
    resetn = 1;
    cyc;
    miss(32'h1c00_0000, 32'h1c00_0000, 1, 1, 64'h0000_0013_0280_0400, 0, 0, 0);
    chk("t6_post_miss_cnt", miss_cnt, 1);

    repeat (2) cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
